// File: rtl/du_imem_loader_if.sv
// du_imem_loader_if: Rx FIFO, imem write port and control/status signals of the program loader
interface du_imem_loader_if #(
    parameter int NB_UART_DATA = 8,
    parameter int NB_INSTR     = 32,
    parameter int NB_IMEM_ADDR = 32
);
    logic                    i_start;
    logic                    i_rx_empty;
    logic [NB_UART_DATA-1:0] i_rx_data;
    logic                    o_rd;
    logic                    o_imem_we;
    logic [NB_IMEM_ADDR-1:0] o_imem_waddr;
    logic [NB_INSTR-1:0]     o_imem_wdata;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_error;
    modport slave (
        input  i_start, i_rx_empty, i_rx_data,
        output o_rd, o_imem_we, o_imem_waddr, o_imem_wdata, o_busy, o_done, o_error
    );
    modport master (
        output i_start, i_rx_empty, i_rx_data,
        input  o_rd, o_imem_we, o_imem_waddr, o_imem_wdata, o_busy, o_done, o_error
    );
endinterface

// File: rtl/du_imem_loader_rx.sv
// du_imem_loader_rx: pops a length-prefixed little-endian byte stream from the UART Rx FIFO into instruction memory
module du_imem_loader_rx #(
    parameter int NB_UART_DATA   = 8,
    parameter int NB_INSTR       = 32,
    parameter int NB_IMEM_ADDR   = 32,
    parameter int IMEM_DEPTH     = 256,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   i_rst,
    du_imem_loader_if.slave        bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(IMEM_DEPTH + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RX_LEN, RX_WORD, WRITE, DONE, ERR} state_t;

    state_t                  r_state;
    logic [NB_INSTR-1:0]     r_word;
    logic [NB_INSTR-1:0]     r_len;
    logic [IW-1:0]           r_idx;
    logic [1:0]              r_bcnt;
    logic [TW-1:0]           r_idle;
    logic                    r_we;
    logic [NB_IMEM_ADDR-1:0] r_waddr;
    logic [NB_INSTR-1:0]     r_wdata;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic                    w_rx;
    logic                    w_pop;
    logic [NB_INSTR-1:0]     w_word;

    assign w_rx   = (r_state == RX_LEN) || (r_state == RX_WORD);
    assign w_pop  = w_rx && !bus.i_rx_empty && !i_rst;
    assign w_word = {bus.i_rx_data, {(NB_INSTR-NB_UART_DATA){1'b0}}} | (r_word >> NB_UART_DATA);

    assign bus.o_rd         = w_pop;
    assign bus.o_imem_we    = r_we;
    assign bus.o_imem_waddr = r_waddr;
    assign bus.o_imem_wdata = r_wdata;
    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
    assign bus.o_error      = r_error;

    // Loader FSM: byte intake, word assembly, imem writes and registered status pulses
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_idle  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        r_state <= RX_LEN;
                        r_bcnt  <= '0;
                        r_idx   <= '0;
                        r_idle  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RX_LEN, RX_WORD: begin
                    if (w_pop) begin
                        r_word <= w_word;
                        r_bcnt <= r_bcnt + 2'd1;
                        r_idle <= '0;
                        if (r_bcnt == 2'd3) begin
                            if (r_state == RX_LEN) begin
                                r_len <= w_word;
                                if (w_word == '0) begin
                                    r_state <= DONE;
                                    r_done  <= 1'b1;
                                end else if (w_word > NB_INSTR'(IMEM_DEPTH)) begin
                                    r_state <= ERR;
                                    r_error <= 1'b1;
                                end else begin
                                    r_state <= RX_WORD;
                                end
                            end else begin
                                r_state <= WRITE;
                                r_we    <= 1'b1;
                                r_waddr <= NB_IMEM_ADDR'({r_idx, 2'b00});
                                r_wdata <= w_word;
                            end
                        end
                    end else if (r_idle == TMAX) begin
                        r_state <= ERR;
                        r_error <= 1'b1;
                    end else begin
                        r_idle <= r_idle + TW'(1);
                    end
                end
                WRITE: begin
                    r_idx <= r_idx + IW'(1);
                    if (NB_INSTR'(r_idx) + NB_INSTR'(1) == r_len) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= RX_WORD;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_du_imem_loader_rx.sv
// tb_du_imem_loader_rx: directed self-checking bench for the imem program loader
module tb_du_imem_loader_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    du_imem_loader_if #(.NB_UART_DATA(8), .NB_INSTR(32), .NB_IMEM_ADDR(32)) bus ();

    du_imem_loader_rx #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .i_rst(rst), .bus(bus));

    logic [7:0]  fifo_mem [256];
    logic [7:0]  head = 8'd0;
    logic [7:0]  tail = 8'd0;
    logic        flush = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_pop = 0;
    int          n_we = 0;
    int          n_done = 0;
    int          n_err = 0;
    int          rd_viol = 0;
    int          done_cyc = 0;
    int          err_cyc = 0;
    int          pop_cyc [256];
    int          we_cyc [256];
    logic [31:0] wa [256];
    logic [31:0] wd [256];
    logic [7:0]  t1 [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

    assign bus.i_rx_empty = (head == tail);
    assign bus.i_rx_data  = fifo_mem[head];

    // FIFO model and event recorder; records cycle numbers of pops, writes, done and error
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flush) head <= tail;
        else if (bus.o_rd) begin
            head <= head + 8'd1;
            pop_cyc[n_pop] <= cyc;
            n_pop <= n_pop + 1;
        end
        if (bus.o_rd && bus.i_rx_empty) rd_viol <= rd_viol + 1;
        if (bus.o_imem_we) begin
            wa[n_we] <= bus.o_imem_waddr;
            wd[n_we] <= bus.o_imem_wdata;
            we_cyc[n_we] <= cyc;
            n_we <= n_we + 1;
        end
        if (bus.o_done) begin
            done_cyc <= cyc;
            n_done <= n_done + 1;
        end
        if (bus.o_error) begin
            err_cyc <= cyc;
            n_err <= n_err + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        fifo_mem[tail] = b;
        tail = tail + 8'd1;
    endtask

    task automatic do_start();
        @(negedge clk) bus.i_start = 1'b1;
        @(negedge clk) bus.i_start = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk) flush = 1'b1;
        @(negedge clk) flush = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!bus.o_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_t1(output bit ok);
        foreach (t1[i]) push(t1[i]);
        do_start();
        wait_idle(ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        push(8'h55);
        repeat (3) @(negedge clk);
        n_chk++; if (bus.o_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rd: got %b expected 0", bus.o_rd); end
        n_chk++; if (bus.o_imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", bus.o_imem_we); end
        n_chk++; if (bus.o_imem_waddr !== 32'h0) begin n_fail++; $display("FAIL rst_waddr: got %h expected 0", bus.o_imem_waddr); end
        n_chk++; if (bus.o_imem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h expected 0", bus.o_imem_wdata); end
        n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.o_busy); end
        n_chk++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", bus.o_done); end
        n_chk++; if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b expected 0", bus.o_error); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++; if (n_pop !== 0) begin n_fail++; $display("FAIL idle_no_pop: got %0d pops expected 0", n_pop); end
        n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.o_busy); end
        do_flush();
    endtask

    task automatic test_n2();
        int bw, bp, bd, be;
        bit ok;
        bw = n_we; bp = n_pop; bd = n_done; be = n_err;
        load_t1(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL t1_idle: busy still %b after 400 cycles, expected 0", bus.o_busy); end
        n_chk++; if (n_we - bw !== 2) begin n_fail++; $display("FAIL t1_we_cnt: got %0d expected 2", n_we - bw); end
        n_chk++; if (wa[bw] !== 32'h0) begin n_fail++; $display("FAIL t1_addr0: got %h expected 00000000", wa[bw]); end
        n_chk++; if (wd[bw] !== 32'h00100513) begin n_fail++; $display("FAIL t1_data0: got %h expected 00100513", wd[bw]); end
        n_chk++; if (wa[bw+1] !== 32'h4) begin n_fail++; $display("FAIL t1_addr1: got %h expected 00000004", wa[bw+1]); end
        n_chk++; if (wd[bw+1] !== 32'h00200593) begin n_fail++; $display("FAIL t1_data1: got %h expected 00200593", wd[bw+1]); end
        n_chk++; if (n_pop - bp !== 12) begin n_fail++; $display("FAIL t1_pops: got %0d expected 12", n_pop - bp); end
        n_chk++; if (we_cyc[bw+1] !== pop_cyc[bp+11] + 1) begin n_fail++; $display("FAIL t1_we_lat: got cycle %0d expected %0d", we_cyc[bw+1], pop_cyc[bp+11] + 1); end
        n_chk++; if (n_done - bd !== 1) begin n_fail++; $display("FAIL t1_done_cnt: got %0d expected 1", n_done - bd); end
        n_chk++; if (done_cyc !== we_cyc[bw+1] + 1) begin n_fail++; $display("FAIL t1_done_lat: got cycle %0d expected %0d", done_cyc, we_cyc[bw+1] + 1); end
        n_chk++; if (n_err - be !== 0) begin n_fail++; $display("FAIL t1_err: got %0d expected 0", n_err - be); end
        n_chk++; if (bus.o_imem_wdata !== 32'h0) begin n_fail++; $display("FAIL t1_idle_wdata: got %h expected 0", bus.o_imem_wdata); end
    endtask

    task automatic test_n0();
        int bw, bp, bd, be;
        bit ok;
        bw = n_we; bp = n_pop; bd = n_done; be = n_err;
        repeat (4) push(8'h00);
        do_start();
        wait_idle(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL t2_idle: busy still %b, expected 0", bus.o_busy); end
        n_chk++; if (n_we - bw !== 0) begin n_fail++; $display("FAIL t2_we_cnt: got %0d expected 0", n_we - bw); end
        n_chk++; if (n_done - bd !== 1) begin n_fail++; $display("FAIL t2_done_cnt: got %0d expected 1", n_done - bd); end
        n_chk++; if (done_cyc !== pop_cyc[bp+3] + 1) begin n_fail++; $display("FAIL t2_done_lat: got cycle %0d expected %0d", done_cyc, pop_cyc[bp+3] + 1); end
        n_chk++; if (n_err - be !== 0) begin n_fail++; $display("FAIL t2_err: got %0d expected 0", n_err - be); end
    endtask

    task automatic test_len_overflow();
        int bw, bp, bd, be;
        bit ok;
        bw = n_we; bp = n_pop; bd = n_done; be = n_err;
        push(8'h01); push(8'h01); push(8'h00); push(8'h00); push(8'hAA); push(8'hBB);
        do_start();
        wait_idle(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL t3_idle: busy still %b, expected 0", bus.o_busy); end
        n_chk++; if (n_err - be !== 1) begin n_fail++; $display("FAIL t3_err_cnt: got %0d expected 1", n_err - be); end
        n_chk++; if (err_cyc !== pop_cyc[bp+3] + 1) begin n_fail++; $display("FAIL t3_err_lat: got cycle %0d expected %0d", err_cyc, pop_cyc[bp+3] + 1); end
        n_chk++; if (n_pop - bp !== 4) begin n_fail++; $display("FAIL t3_pops: got %0d expected 4", n_pop - bp); end
        n_chk++; if (8'(tail - head) !== 8'd2) begin n_fail++; $display("FAIL t3_left: got %0d bytes expected 2", 8'(tail - head)); end
        n_chk++; if (n_we - bw !== 0) begin n_fail++; $display("FAIL t3_we_cnt: got %0d expected 0", n_we - bw); end
        n_chk++; if (n_done - bd !== 0) begin n_fail++; $display("FAIL t3_done: got %0d expected 0", n_done - bd); end
        do_flush();
    endtask

    task automatic test_timeout();
        int bw, bp, bd, be;
        bit ok;
        bw = n_we; bp = n_pop; bd = n_done; be = n_err;
        push(8'h01); push(8'h00); push(8'h00); push(8'h00); push(8'hAA); push(8'hBB);
        do_start();
        wait_idle(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL t4_idle: busy still %b, expected 0", bus.o_busy); end
        n_chk++; if (n_err - be !== 1) begin n_fail++; $display("FAIL t4_err_cnt: got %0d expected 1", n_err - be); end
        n_chk++; if (err_cyc !== pop_cyc[bp+5] + 17) begin n_fail++; $display("FAIL t4_err_lat: got cycle %0d expected %0d", err_cyc, pop_cyc[bp+5] + 17); end
        n_chk++; if (n_we - bw !== 0) begin n_fail++; $display("FAIL t4_we_cnt: got %0d expected 0", n_we - bw); end
        n_chk++; if (n_done - bd !== 0) begin n_fail++; $display("FAIL t4_done: got %0d expected 0", n_done - bd); end
        bw = n_we;
        load_t1(ok);
        n_chk++; if (n_we - bw !== 2) begin n_fail++; $display("FAIL t4_reload_cnt: got %0d expected 2", n_we - bw); end
        n_chk++; if (wd[bw] !== 32'h00100513) begin n_fail++; $display("FAIL t4_reload_data0: got %h expected 00100513", wd[bw]); end
        n_chk++; if (wa[bw+1] !== 32'h4) begin n_fail++; $display("FAIL t4_reload_addr1: got %h expected 00000004", wa[bw+1]); end
    endtask

    task automatic test_gaps();
        int bw, bd, be;
        int gaps [12] = '{3, 0, 7, 1, 12, 2, 0, 9, 5, 13, 1, 4};
        bit ok;
        bw = n_we; bd = n_done; be = n_err;
        do_start();
        for (int i = 0; i < 12; i++) begin
            repeat (gaps[i]) @(negedge clk);
            if (i == 5) begin
                bus.i_start = 1'b1;
                @(negedge clk) bus.i_start = 1'b0;
            end
            push(t1[i]);
            @(negedge clk);
        end
        wait_idle(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL t5_idle: busy still %b, expected 0", bus.o_busy); end
        n_chk++; if (n_we - bw !== 2) begin n_fail++; $display("FAIL t5_we_cnt: got %0d expected 2", n_we - bw); end
        n_chk++; if (wa[bw] !== 32'h0 || wd[bw] !== 32'h00100513) begin n_fail++; $display("FAIL t5_w0: got %h/%h expected 00000000/00100513", wa[bw], wd[bw]); end
        n_chk++; if (wa[bw+1] !== 32'h4 || wd[bw+1] !== 32'h00200593) begin n_fail++; $display("FAIL t5_w1: got %h/%h expected 00000004/00200593", wa[bw+1], wd[bw+1]); end
        n_chk++; if (n_done - bd !== 1 || n_err - be !== 0) begin n_fail++; $display("FAIL t5_status: got done %0d err %0d expected 1 0", n_done - bd, n_err - be); end
        n_chk++; if (rd_viol !== 0) begin n_fail++; $display("FAIL t5_rd_empty: got %0d pops while empty expected 0", rd_viol); end
    endtask

    task automatic test_reset_mid_load();
        int bw, bp;
        bit ok;
        bw = n_we; bp = n_pop;
        foreach (t1[i]) push(t1[i]);
        do_start();
        for (int i = 0; i < 100 && n_pop - bp < 6; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (n_pop - bp !== 6) begin n_fail++; $display("FAIL t6_pops: got %0d expected 6", n_pop - bp); end
        n_chk++; if ({bus.o_rd, bus.o_imem_we, bus.o_busy, bus.o_done, bus.o_error} !== 5'b0) begin n_fail++; $display("FAIL t6_ctl: got %b expected 00000", {bus.o_rd, bus.o_imem_we, bus.o_busy, bus.o_done, bus.o_error}); end
        n_chk++; if (bus.o_imem_waddr !== 32'h0 || bus.o_imem_wdata !== 32'h0) begin n_fail++; $display("FAIL t6_bus: got %h/%h expected 0/0", bus.o_imem_waddr, bus.o_imem_wdata); end
        n_chk++; if (n_we - bw !== 0) begin n_fail++; $display("FAIL t6_we_cnt: got %0d expected 0", n_we - bw); end
        rst = 1'b0;
        do_flush();
        bw = n_we;
        load_t1(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL t6_idle: busy still %b, expected 0", bus.o_busy); end
        n_chk++; if (n_we - bw !== 2) begin n_fail++; $display("FAIL t6_we_cnt2: got %0d expected 2", n_we - bw); end
        n_chk++; if (wa[bw] !== 32'h0 || wd[bw] !== 32'h00100513) begin n_fail++; $display("FAIL t6_w0: got %h/%h expected 00000000/00100513", wa[bw], wd[bw]); end
        n_chk++; if (wa[bw+1] !== 32'h4 || wd[bw+1] !== 32'h00200593) begin n_fail++; $display("FAIL t6_w1: got %h/%h expected 00000004/00200593", wa[bw+1], wd[bw+1]); end
    endtask

    initial begin
        bus.i_start = 1'b0;
        test_reset();
        test_n2();
        test_n0();
        test_len_overflow();
        test_timeout();
        test_gaps();
        test_reset_mid_load();
        n_chk++; if (rd_viol !== 0) begin n_fail++; $display("FAIL rd_while_empty: got %0d expected 0", rd_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
